// File: rtl/rr_packed_logb_gearbox.sv
// Repacks variable-length packed logb chunks into gap-free OUT_WIDTH words
// behind a small output FIFO, with flush-to-residue and almost-full feedback.
module rr_packed_logb_gearbox #(
  parameter int IN_WIDTH     = 512,
  parameter int OUT_WIDTH    = 512,
  parameter int FIFO_DEPTH   = 32,
  parameter int ALMFUL_SLACK = 8,
  parameter int LEN_WIDTH    = $clog2(IN_WIDTH+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [IN_WIDTH-1:0]            in_data,
  input  logic [LEN_WIDTH-1:0]           in_len,
  output logic                           in_almful,
  input  logic                           flush,
  output logic                           flush_done,
  output logic                           out_valid,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic                           out_last,
  output logic [$clog2(OUT_WIDTH+1)-1:0] out_bits,
  input  logic                           out_ready,
  output logic                           overflow_err,
  output logic                           protocol_err,
  output logic [63:0]                    word_cnt,
  output logic                           dbg_state,
  output logic [$clog2(OUT_WIDTH+1)-1:0] dbg_fill
);

  localparam int ACC_W   = 2 * OUT_WIDTH;
  localparam int SUM_W   = $clog2(2 * OUT_WIDTH + 1);
  localparam int BITS_W  = $clog2(OUT_WIDTH + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + BITS_W + OUT_WIDTH;
  localparam logic [IN_WIDTH-1:0] ONES = '1;

  if (IN_WIDTH > OUT_WIDTH) begin : g_bad_width
    $error("IN_WIDTH must not exceed OUT_WIDTH");
  end
  if (FIFO_DEPTH < 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 8");
  end

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [BITS_W-1:0]   fill_q, fill_d;
  logic                flush_done_q, flush_done_d;
  logic                overflow_q, overflow_d;
  logic                protocol_q, protocol_d;
  logic [63:0]         word_cnt_q, word_cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];

  logic [LEN_WIDTH-1:0] eff_len;
  logic [IN_WIDTH-1:0]  masked;
  logic [ACC_W-1:0]     acc_merged;
  logic [SUM_W-1:0]     sum;
  logic                 push, push_last, push_ok, pop, full;
  logic [OUT_WIDTH-1:0] push_data;
  logic [BITS_W-1:0]    push_bits;

  // Packing datapath and RUN/FLUSH_DRAIN control.
  always_comb begin
    eff_len      = in_valid ? in_len : '0;
    masked       = in_data & ~(ONES << eff_len);
    acc_merged   = acc_q | (ACC_W'(masked) << fill_q);
    sum          = SUM_W'(fill_q) + SUM_W'(eff_len);
    state_d      = state_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    push         = 1'b0;
    push_data    = '0;
    push_bits    = '0;
    push_last    = 1'b0;
    flush_done_d = 1'b0;
    protocol_d   = protocol_q;
    case (state_q)
      ST_RUN: begin
        if (sum >= SUM_W'(OUT_WIDTH)) begin
          push      = 1'b1;
          push_data = acc_merged[OUT_WIDTH-1:0];
          push_bits = BITS_W'(OUT_WIDTH);
          acc_d     = acc_merged >> OUT_WIDTH;
          fill_d    = BITS_W'(sum - SUM_W'(OUT_WIDTH));
        end else begin
          acc_d  = acc_merged;
          fill_d = BITS_W'(sum);
        end
        if (flush) begin
          if (fill_d == '0) begin
            push_last    = push;
            flush_done_d = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Bits above fill are already zero, so the residue is naturally padded.
        push         = 1'b1;
        push_data    = acc_q[OUT_WIDTH-1:0];
        push_bits    = fill_q;
        push_last    = 1'b1;
        acc_d        = '0;
        fill_d       = '0;
        flush_done_d = 1'b1;
        state_d      = ST_RUN;
        if (in_valid || flush) protocol_d = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output handshake: a word transfers on a cycle where out_valid && out_ready;
  // out_valid never depends on out_ready. A push into a full FIFO is accepted
  // only when the head is popped in the same cycle, otherwise it is dropped.
  always_comb begin
    pop        = (count_q != '0) && out_ready;
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    push_ok    = push && (!full || pop);
    overflow_d = overflow_q | (push && full && !pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    word_cnt_d = push_ok ? word_cnt_q + 64'd1 : word_cnt_q;
    count_d    = count_q;
    if (push_ok && !pop) count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      flush_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      protocol_q   <= 1'b0;
      word_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_done_q <= flush_done_d;
      overflow_q   <= overflow_d;
      protocol_q   <= protocol_d;
      word_cnt_q   <= word_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_last, push_bits, push_data};
  end

  always_comb begin
    out_valid = (count_q != '0);
    {out_last, out_bits, out_data} = out_valid ? mem_q[rd_ptr_q] : '0;
    in_almful    = (FIFO_DEPTH - int'(count_q)) <= ALMFUL_SLACK;
    flush_done   = flush_done_q;
    overflow_err = overflow_q;
    protocol_err = protocol_q;
    word_cnt     = word_cnt_q;
    dbg_state    = state_q;
    dbg_fill     = fill_q;
  end

endmodule

// File: tb/tb_rr_packed_logb_gearbox.sv
// Directed bench for rr_packed_logb_gearbox: packing, flush, backpressure,
// protocol error and reset behaviour with hand-derived expected words.
module tb_rr_packed_logb_gearbox;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [511:0] in_data;
  logic [9:0]   in_len;
  logic         in_almful;
  logic         flush;
  logic         flush_done;
  logic         out_valid;
  logic [511:0] out_data;
  logic         out_last;
  logic [9:0]   out_bits;
  logic         out_ready;
  logic         overflow_err;
  logic         protocol_err;
  logic [63:0]  word_cnt;
  logic         dbg_state;
  logic [9:0]   dbg_fill;

  int n_checks = 0;
  int n_errors = 0;

  rr_packed_logb_gearbox dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_len(in_len),
    .in_almful(in_almful), .flush(flush), .flush_done(flush_done),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_bits(out_bits), .out_ready(out_ready),
    .overflow_err(overflow_err), .protocol_err(protocol_err),
    .word_cnt(word_cnt), .dbg_state(dbg_state), .dbg_fill(dbg_fill)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_cycle(input logic v, input logic [9:0] len, input logic [511:0] d, input logic fl);
    in_valid = v; in_len = len; in_data = d; flush = fl;
    @(posedge clk); #1;
    in_valid = 1'b0; in_len = '0; in_data = '0; flush = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [511:0] a, b, c, d, e, f, g, h, w, first_bp, second_bp;
  logic [511:0] fw [4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_almful", in_almful, 0);
    check_eq("reset_word_cnt", word_cnt, 0);
    check_eq("reset_errs", {overflow_err, protocol_err, flush_done}, 0);
    check_eq("reset_fill", dbg_fill, 0);

    // Length sweep 200/200/(len 0)/200: first word spans all three chunks.
    a = rand512(); b = rand512(); c = rand512(); d = rand512();
    drive_cycle(1'b1, 10'd200, a, 1'b0);
    check_eq("sweep_fill1", dbg_fill, 200);
    check_eq("sweep_novalid1", out_valid, 0);
    drive_cycle(1'b1, 10'd200, b, 1'b0);
    check_eq("sweep_fill2", dbg_fill, 400);
    drive_cycle(1'b1, 10'd0, rand512(), 1'b0);
    check_eq("len0_fill", dbg_fill, 400);
    check_eq("len0_novalid", out_valid, 0);
    drive_cycle(1'b1, 10'd200, c, 1'b0);
    check_eq("sweep_valid", out_valid, 1);
    check_eq("sweep_fill3", dbg_fill, 88);
    check_eq("sweep_word", out_data, {c[111:0], b[199:0], a[199:0]});
    check_eq("sweep_bits", out_bits, 512);
    check_eq("sweep_last", out_last, 0);

    // Flush with residue 88 + 500: full word, then a 76-bit final word.
    drive_cycle(1'b1, 10'd500, d, 1'b1);
    check_eq("flush_drain_state", dbg_state, 1);
    check_eq("flush_done_early", flush_done, 0);
    drive_cycle(1'b0, 10'd0, '0, 1'b0);
    check_eq("flush_done_pulse", flush_done, 1);
    check_eq("flush_fill0", dbg_fill, 0);
    check_eq("flush_run_state", dbg_state, 0);
    pop_one();
    check_eq("flush_done_clear", flush_done, 0);
    check_eq("flush_w2_data", out_data, {d[423:0], c[199:112]});
    check_eq("flush_w2_last", out_last, 0);
    check_eq("flush_w2_bits", out_bits, 512);
    pop_one();
    w = '0; w[75:0] = d[499:424];
    check_eq("flush_w3_data", out_data, w);
    check_eq("flush_w3_bits", out_bits, 76);
    check_eq("flush_w3_last", out_last, 1);
    pop_one();
    check_eq("flush_empty", out_valid, 0);

    // Empty flush: no word, single flush_done pulse.
    drive_cycle(1'b0, 10'd0, '0, 1'b1);
    check_eq("eflush_done", flush_done, 1);
    check_eq("eflush_novalid", out_valid, 0);
    drive_cycle(1'b0, 10'd0, '0, 1'b0);
    check_eq("eflush_done_once", flush_done, 0);

    // Flush on an exact boundary: 312 + 200.
    e = rand512(); f = rand512();
    drive_cycle(1'b1, 10'd312, e, 1'b0);
    check_eq("bflush_fill", dbg_fill, 312);
    drive_cycle(1'b1, 10'd200, f, 1'b1);
    check_eq("bflush_valid", out_valid, 1);
    check_eq("bflush_data", out_data, {f[199:0], e[311:0]});
    check_eq("bflush_last", out_last, 1);
    check_eq("bflush_bits", out_bits, 512);
    check_eq("bflush_done", flush_done, 1);
    check_eq("bflush_state", dbg_state, 0);
    pop_one();
    check_eq("bflush_empty", out_valid, 0);
    check_eq("word_cnt_4", word_cnt, 4);

    // Full-width chunks streaming through with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fw[i] = rand512();
      drive_cycle(1'b1, 10'd0, fw[i], 1'b0);
      in_len = 10'd0;
    end
    out_ready = 1'b0;
    check_eq("len0_512_novalid", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 10'd512, fw[i], 1'b0);
      check_eq("fullw_valid", out_valid, 1);
      check_eq("fullw_data", out_data, fw[i]);
      check_eq("fullw_fill", dbg_fill, 0);
    end
    drive_cycle(1'b0, 10'd0, '0, 1'b0);
    out_ready = 1'b0;
    check_eq("fullw_drained", out_valid, 0);
    check_eq("word_cnt_8", word_cnt, 8);

    // Input during FLUSH_DRAIN is discarded and flagged.
    g = rand512(); h = rand512();
    drive_cycle(1'b1, 10'd10, g, 1'b0);
    drive_cycle(1'b0, 10'd0, '0, 1'b1);
    check_eq("proto_drain_state", dbg_state, 1);
    drive_cycle(1'b1, 10'd512, h, 1'b0);
    check_eq("proto_err", protocol_err, 1);
    check_eq("proto_fill", dbg_fill, 0);
    w = '0; w[9:0] = g[9:0];
    check_eq("proto_res_data", out_data, w);
    check_eq("proto_res_bits", out_bits, 10);
    check_eq("proto_res_last", out_last, 1);
    pop_one();
    check_eq("proto_chunk_absent", out_valid, 0);
    check_eq("proto_sticky", protocol_err, 1);

    do_reset();
    check_eq("rst_proto_clear", protocol_err, 0);

    // Backpressure: fill the FIFO, then overflow on the 33rd push.
    for (int k = 1; k <= 33; k++) begin
      w = rand512();
      if (k == 1) first_bp = w;
      if (k == 2) second_bp = w;
      drive_cycle(1'b1, 10'd512, w, 1'b0);
      if (k == 23) check_eq("bp_almful_23", in_almful, 0);
      if (k == 24) check_eq("bp_almful_24", in_almful, 1);
      if (k == 32) begin
        check_eq("bp_cnt_32", word_cnt, 32);
        check_eq("bp_no_ovf_32", overflow_err, 0);
      end
    end
    check_eq("bp_overflow", overflow_err, 1);
    check_eq("bp_cnt_33", word_cnt, 32);
    check_eq("bp_head", out_data, first_bp);
    out_ready = 1'b1;
    drive_cycle(1'b1, 10'd512, rand512(), 1'b0);
    out_ready = 1'b0;
    check_eq("bp_pushpop_cnt", word_cnt, 33);
    check_eq("bp_pushpop_head", out_data, second_bp);
    check_eq("bp_pushpop_almful", in_almful, 1);
    check_eq("bp_ovf_sticky", overflow_err, 1);

    // Reset mid-stream discards residue, FIFO contents and errors.
    drive_cycle(1'b1, 10'd100, rand512(), 1'b0);
    check_eq("mid_fill", dbg_fill, 100);
    do_reset();
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_fill", dbg_fill, 0);
    check_eq("mid_rst_ovf", overflow_err, 0);
    check_eq("mid_rst_cnt", word_cnt, 0);
    check_eq("mid_rst_almful", in_almful, 0);
    check_eq("mid_rst_data", out_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
